// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared constants and next-PC source encoding for the fetch PC
// Purpose: default widths/depths plus the encoding of where the next PC comes from.
// Ports: none (package).
package pc_pkg;

    localparam int ANCHO_DEF    = 32;
    localparam int PASO_DEF     = 1;
    localparam int PROF_RAS_DEF = 4;

    typedef enum logic [2:0] {
        SEQ    = 3'd0,
        BRANCH = 3'd1,
        JUMP   = 3'd2,
        CALL   = 3'd3,
        RET    = 3'd4
    } fuente_pc_t;

endpackage

// File: rtl/pila_retorno.sv
// rtl/pila_retorno.sv - circular return-address stack
// Purpose: LIFO of return addresses; a push onto a full stack overwrites the oldest entry.
// Ports: clk, reset (sync active-low), push, pop, dato (pushed value),
//        top (current top entry), count, lleno (full), vacio (empty).
module pila_retorno
    import pc_pkg::*;
#(
    parameter int ANCHO    = ANCHO_DEF,
    parameter int PROF_RAS = PROF_RAS_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic [ANCHO-1:0]            dato,
    output logic [ANCHO-1:0]            top,
    output logic [$clog2(PROF_RAS):0]   count,
    output logic                        lleno,
    output logic                        vacio
);

    localparam int PW = $clog2(PROF_RAS);
    localparam logic [PW-1:0] PTR_UNO = 1;
    localparam logic [PW:0]   CNT_UNO = 1;
    localparam logic [PW:0]   CNT_MAX = (PW+1)'(PROF_RAS);

    logic [ANCHO-1:0] r_mem [PROF_RAS];
    logic [PW-1:0]    r_ptr;
    logic [PW:0]      r_count;
    logic [PW-1:0]    w_ptr_sig;

    // r_ptr addresses the top entry; the pointer wraps, so a push when full
    // lands on the slot holding the oldest entry.
    assign w_ptr_sig = r_ptr + PTR_UNO;
    assign top       = r_mem[r_ptr];
    assign count     = r_count;
    assign lleno     = (r_count == CNT_MAX);
    assign vacio     = (r_count == '0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (push) begin
            r_mem[w_ptr_sig] <= dato;
            r_ptr            <= w_ptr_sig;
            if (!lleno) begin
                r_count <= r_count + CNT_UNO;
            end
        end else if (pop && !vacio) begin
            r_ptr   <= r_ptr - PTR_UNO;
            r_count <= r_count - CNT_UNO;
        end
    end

endmodule

// File: rtl/pc_segmentado_ras.sv
// rtl/pc_segmentado_ras.sv - pipelined fetch PC with branches, jumps and return-address stack
// Purpose: registered fetch address advancing on accepted fetches, selecting
//          return > call > jump > taken branch > sequential.
// Ports: clk, reset (sync active-low), stall, mem_listo, SaltoCond, modo_bne, oZero,
//        extSigno, Salto, llamada, retorno, dir_salto -> direinstru, req_mem,
//        ras_vacio, ras_lleno, error_ras.
module pc_segmentado_ras
    import pc_pkg::*;
#(
    parameter int ANCHO        = ANCHO_DEF,
    parameter int PASO         = PASO_DEF,
    parameter int DESP         = 0,
    parameter int VECTOR_RESET = 0,
    parameter int PROF_RAS     = PROF_RAS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             mem_listo,
    input  logic             SaltoCond,
    input  logic             modo_bne,
    input  logic             oZero,
    input  logic [ANCHO-1:0] extSigno,
    input  logic             Salto,
    input  logic             llamada,
    input  logic             retorno,
    input  logic [ANCHO-1:0] dir_salto,
    output logic [ANCHO-1:0] direinstru,
    output logic             req_mem,
    output logic             ras_vacio,
    output logic             ras_lleno,
    output logic             error_ras
);

    localparam int PW = $clog2(PROF_RAS);
    localparam logic [ANCHO-1:0] PASO_W  = ANCHO'(PASO);
    localparam logic [ANCHO-1:0] RESET_W = ANCHO'(VECTOR_RESET);
    localparam logic [PW:0]      CNT_MAX = (PW+1)'(PROF_RAS);

    logic [ANCHO-1:0] r_pc;
    logic             r_req;
    logic             r_err;

    logic             w_avanzar;
    fuente_pc_t       w_fuente;
    logic             w_error;
    logic [ANCHO-1:0] w_seq;
    logic [ANCHO-1:0] w_branch;
    logic [ANCHO-1:0] w_next;
    logic [ANCHO-1:0] w_top;
    logic [PW:0]      w_count;
    logic             w_lleno;
    logic             w_vacio;
    logic             w_push;
    logic             w_pop;

    assign w_avanzar = r_req && mem_listo && !stall;
    assign w_seq     = r_pc + PASO_W;
    assign w_branch  = w_seq + (extSigno << DESP);

    // Source selection and illegal-stack detection. A return on an empty
    // stack falls back to sequential; a call alongside a return is dropped.
    always_comb begin
        w_fuente = SEQ;
        w_error  = 1'b0;
        if (retorno) begin
            if (w_vacio) begin
                w_fuente = SEQ;
                w_error  = 1'b1;
            end else begin
                w_fuente = RET;
            end
            if (llamada) begin
                w_error = 1'b1;
            end
        end else if (llamada) begin
            w_fuente = CALL;
            w_error  = w_lleno;
        end else if (Salto) begin
            w_fuente = JUMP;
        end else if (SaltoCond && (oZero ^ modo_bne)) begin
            w_fuente = BRANCH;
        end
    end

    always_comb begin
        w_next = w_seq;
        case (w_fuente)
            BRANCH:  w_next = w_branch;
            JUMP:    w_next = dir_salto;
            CALL:    w_next = dir_salto;
            RET:     w_next = w_top;
            default: w_next = w_seq;
        endcase
    end

    assign w_push = w_avanzar && (w_fuente == CALL);
    assign w_pop  = w_avanzar && (w_fuente == RET);

    pila_retorno #(
        .ANCHO    (ANCHO),
        .PROF_RAS (PROF_RAS)
    ) u_pila (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .dato  (w_seq),
        .top   (w_top),
        .count (w_count),
        .lleno (w_lleno),
        .vacio (w_vacio)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc  <= RESET_W;
            r_req <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_req <= 1'b1;
            r_err <= w_avanzar && w_error;
            if (w_avanzar) begin
                r_pc <= w_next;
            end
        end
    end

    assign direinstru = r_pc;
    assign req_mem    = r_req;
    assign error_ras  = r_err;
    assign ras_vacio  = (w_count == '0);
    assign ras_lleno  = (w_count == CNT_MAX);

endmodule

// File: tb/tb_pc_segmentado_ras.sv
// tb/tb_pc_segmentado_ras.sv - self-checking bench for pc_segmentado_ras
module tb_pc_segmentado_ras;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        mem_listo = 1'b0;
    logic        scond = 1'b0;
    logic        mbne = 1'b0;
    logic        ozero = 1'b0;
    logic [31:0] ext = '0;
    logic        salto = 1'b0;
    logic        llam = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] dir = '0;

    logic [31:0] pc_a;
    logic        req_a, vac_a, lle_a, err_a;
    logic [7:0]  pc_b;
    logic        req_b, vac_b, lle_b, err_b;

    int checks = 0;
    int failures = 0;
    logic [31:0] q_exp[$];

    always #5 clk = ~clk;

    pc_segmentado_ras dut_a (
        .clk(clk), .reset(reset), .stall(stall), .mem_listo(mem_listo),
        .SaltoCond(scond), .modo_bne(mbne), .oZero(ozero), .extSigno(ext),
        .Salto(salto), .llamada(llam), .retorno(ret), .dir_salto(dir),
        .direinstru(pc_a), .req_mem(req_a), .ras_vacio(vac_a),
        .ras_lleno(lle_a), .error_ras(err_a)
    );

    pc_segmentado_ras #(.ANCHO(8)) dut_b (
        .clk(clk), .reset(reset), .stall(stall), .mem_listo(mem_listo),
        .SaltoCond(scond), .modo_bne(mbne), .oZero(ozero), .extSigno(ext[7:0]),
        .Salto(salto), .llamada(llam), .retorno(ret), .dir_salto(dir[7:0]),
        .direinstru(pc_b), .req_mem(req_b), .ras_vacio(vac_b),
        .ras_lleno(lle_b), .error_ras(err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected PC is queued when the controls are applied, compared after the edge.
    task automatic step(input string tag, input logic [31:0] exp);
        logic [31:0] e;
        q_exp.push_back(exp);
        tick();
        e = q_exp.pop_front();
        chk(tag, pc_a, e);
    endtask

    task automatic clr();
        stall = 0; scond = 0; mbne = 0; ozero = 0; ext = '0;
        salto = 0; llam = 0; ret = 0; dir = '0;
    endtask

    task automatic jump_to(input logic [31:0] a);
        clr(); salto = 1; dir = a;
        step("jump", a);
        clr();
    endtask

    initial begin
        tick(); tick();
        chk("rst_pc", pc_a, 32'h0);
        chk("rst_req", {31'b0, req_a}, 32'd0);
        chk("rst_vacio", {31'b0, vac_a}, 32'd1);
        chk("rst_lleno", {31'b0, lle_a}, 32'd0);
        chk("rst_err", {31'b0, err_a}, 32'd0);
        chk("rst_b", {28'b0, req_b, vac_b, lle_b, err_b}, 32'b0100);

        reset = 1; mem_listo = 1;
        step("first_fetch", 32'h0);
        chk("req_rise", {31'b0, req_a}, 32'd1);
        step("seq1", 32'h1);
        step("seq2", 32'h2);
        step("seq3", 32'h3);
        step("seq4", 32'h4);
        step("seq5", 32'h5);

        scond = 1; mbne = 0; ozero = 1; ext = 32'd3;
        step("beq_taken", 32'h9);
        jump_to(32'h5);
        scond = 1; mbne = 0; ozero = 0; ext = 32'd3;
        step("beq_not", 32'h6);
        jump_to(32'h5);
        scond = 1; mbne = 1; ozero = 0; ext = 32'd3;
        step("bne_taken", 32'h9);

        jump_to(32'h4);
        stall = 1; salto = 1; dir = 32'h40;
        step("stall1", 32'h4);
        step("stall2", 32'h4);
        step("stall3", 32'h4);
        stall = 0;
        step("stall_rel", 32'h40);

        jump_to(32'h10);
        llam = 1; dir = 32'h80;
        step("call", 32'h80);
        chk("call_vacio", {31'b0, vac_a}, 32'd0);
        clr();
        step("c81", 32'h81);
        step("c82", 32'h82);
        step("c83", 32'h83);
        ret = 1;
        step("ret", 32'h11);
        chk("ret_vacio", {31'b0, vac_a}, 32'd1);
        chk("ret_err", {31'b0, err_a}, 32'd0);
        step("ret_empty", 32'h12);
        chk("ret_empty_err", {31'b0, err_a}, 32'd1);
        clr();
        step("after_err", 32'h13);
        chk("err_pulse", {31'b0, err_a}, 32'd0);

        llam = 1; dir = 32'h100; step("call1", 32'h100);
        dir = 32'h200; step("call2", 32'h200);
        dir = 32'h300; step("call3", 32'h300);
        dir = 32'h400; step("call4", 32'h400);
        chk("lleno4", {31'b0, lle_a}, 32'd1);
        chk("err4", {31'b0, err_a}, 32'd0);
        dir = 32'h500; step("call5", 32'h500);
        chk("err5", {31'b0, err_a}, 32'd1);
        chk("lleno5", {31'b0, lle_a}, 32'd1);
        clr(); ret = 1;
        step("pop5", 32'h401);
        step("pop4", 32'h301);
        step("pop3", 32'h201);
        step("pop2", 32'h101);
        chk("pops_vacio", {31'b0, vac_a}, 32'd1);

        clr(); llam = 1; dir = 32'h600;
        step("call6", 32'h600);
        ret = 1; dir = 32'h700;
        step("ret_call", 32'h102);
        chk("ret_call_err", {31'b0, err_a}, 32'd1);
        chk("ret_call_vac", {31'b0, vac_a}, 32'd1);

        clr(); mem_listo = 0;
        step("no_listo", 32'h102);
        chk("no_listo_err", {31'b0, err_a}, 32'd0);
        mem_listo = 1;

        llam = 1; dir = 32'h900;
        step("call9", 32'h900);
        reset = 0; clr();
        step("mid_rst", 32'h0);
        chk("mid_rst_vac", {31'b0, vac_a}, 32'd1);
        chk("mid_rst_err", {31'b0, err_a}, 32'd0);
        chk("mid_rst_req", {31'b0, req_a}, 32'd0);
        reset = 1;
        step("rst_hold", 32'h0);
        ret = 1;
        step("ret_after_rst", 32'h1);
        chk("ret_after_rst_err", {31'b0, err_a}, 32'd1);

        jump_to(32'hFF);
        chk("b_ff", {24'b0, pc_b}, 32'hFF);
        step("a_100", 32'h100);
        chk("b_wrap", {24'b0, pc_b}, 32'h00);
        jump_to(32'h1);
        scond = 1; ozero = 1; mbne = 0; ext = 32'hFFFF_FFFE;
        step("a_neg_branch", 32'h0);
        chk("b_neg_branch", {24'b0, pc_b}, 32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
